// File: rtl/ak16_pkg.sv
// Shared definitions for the Ak-16b MEM stage: sequencer states, default widths
// and the branch-resolution helper.
package ak16_pkg;

    localparam int AK16_ADDR_W = 16;
    localparam int AK16_DATA_W = 16;
    localparam int AK16_PC_W   = 16;
    localparam int TMO_CNT_W   = 8;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_t;

    function automatic logic branch_taken(input logic br, input logic br_ne, input logic zero);
        return (br & zero) | (br_ne & ~zero);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// ACCESS-cycle watchdog for the MEM sequencer; only built with MEM_TIMEOUT_EN.
// Down-counter loaded at request issue; expire marks the last allowed ACCESS cycle.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr
    import ak16_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic expire
);

    logic [TMO_CNT_W-1:0] cnt;

    // Loaded in the issuing IDLE cycle, so the first ACCESS cycle sees TIMEOUT_CYCLES.
    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (load)
            cnt <= TMO_CNT_W'(TIMEOUT_CYCLES);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == TMO_CNT_W'(1));

endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: stalls on outstanding data-memory accesses, returns load data,
// resolves BEQ/BNE. Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
    import ak16_pkg::*;
#(
    parameter int ADDR_W         = AK16_ADDR_W,
    parameter int DATA_W         = AK16_DATA_W,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_mem_read,
    input  logic                 mem_mem_write,
    input  logic [ADDR_W-1:0]    mem_alu_result,
    input  logic [DATA_W-1:0]    mem_rs2_data,
    input  logic                 mem_branch,
    input  logic                 mem_branch_ne,
    input  logic                 mem_zero,
    input  logic [AK16_PC_W-1:0] mem_branch_target,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]    dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [DATA_W-1:0]    dmem_rdata,
    output logic                 stall_mem,
    output logic                 flush_mem,
    output logic                 flush_front,
    output logic                 pc_redirect,
    output logic [AK16_PC_W-1:0] pc_redirect_target,
    output logic [DATA_W-1:0]    load_data,
    output logic                 load_valid,
    output logic                 busy,
    output logic                 timeout_err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    mem_state_t state;
    logic       access;
    logic       in_idle;
    logic       in_access;
    logic       br_fire;
    logic       tmo_expire;

    assign access    = mem_mem_read | mem_mem_write;
    assign in_idle   = (state == MEM_IDLE);
    assign in_access = (state == MEM_ACCESS);

    // Access outranks a branch in the same instruction (illegal encoding).
    assign br_fire = in_idle & ~access & branch_taken(mem_branch, mem_branch_ne, mem_zero);

    assign stall_mem          = (in_idle & access) | in_access;
    assign flush_mem          = br_fire;
    assign flush_front        = br_fire;
    assign pc_redirect        = br_fire;
    assign pc_redirect_target = mem_branch_target;
    assign busy               = ~in_idle;

`ifdef MEM_TIMEOUT_EN
    logic ctr_expire;

    mem_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .load   (in_idle & access),
        .clear  (in_access & dmem_ack),
        .expire (ctr_expire)
    );

    assign tmo_expire = ctr_expire & in_access;

    always_ff @(posedge clk) begin
        if (!rst)
            timeout_err <= 1'b0;
        else if (tmo_expire & ~dmem_ack)
            timeout_err <= 1'b1;
    end
`else
    assign tmo_expire  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= MEM_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (access) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_mem_write;
                        dmem_addr  <= mem_alu_result;
                        dmem_wdata <= mem_rs2_data;
                        state      <= MEM_ACCESS;
                    end
                end
                MEM_ACCESS: begin
                    // An ack arriving on the expiry cycle still completes normally.
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            load_data  <= dmem_rdata;
                            load_valid <= 1'b1;
                        end
                        state <= MEM_DONE;
                    end else if (tmo_expire) begin
                        dmem_req   <= 1'b0;
                        load_data  <= '0;
                        load_valid <= 1'b1;
                        state      <= MEM_DONE;
                    end
                end
                MEM_DONE: state <= MEM_IDLE;
                default:  state <= MEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected requests, loads and
// redirects; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_access_ctrl;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_mem_read = 1'b0, mem_mem_write = 1'b0;
    logic [AW-1:0] mem_alu_result = '0;
    logic [DW-1:0] mem_rs2_data = '0;
    logic          mem_branch = 1'b0, mem_branch_ne = 1'b0, mem_zero = 1'b0;
    logic [15:0]   mem_branch_target = '0;
    logic          dmem_req, dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    logic          stall_mem, flush_mem, flush_front, pc_redirect;
    logic [15:0]   pc_redirect_target;
    logic [DW-1:0] load_data;
    logic          load_valid, busy, timeout_err;

    logic          ack_model = 1'b0, force_ack = 1'b0;
    logic [DW-1:0] rd_model = '0, rd_force = '0, rd_val = '0;
    logic          mem_en = 1'b1;
    int            ack_delay = 0;

    assign dmem_ack   = ack_model | force_ack;
    assign dmem_rdata = force_ack ? rd_force : rd_model;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data),
        .mem_branch(mem_branch), .mem_branch_ne(mem_branch_ne), .mem_zero(mem_zero),
        .mem_branch_target(mem_branch_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem), .flush_mem(flush_mem), .flush_front(flush_front),
        .pc_redirect(pc_redirect), .pc_redirect_target(pc_redirect_target),
        .load_data(load_data), .load_valid(load_valid), .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    req_t          req_exp[$];
    logic [DW-1:0] ld_exp[$];
    logic [15:0]   br_exp[$];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=none", name, act);
    endtask

    // Memory responder: acks ack_delay cycles into the request, once per request.
    initial begin : memory
        int  wcnt;
        logic acked;
        wcnt  = 0;
        acked = 1'b0;
        forever begin
            @(negedge clk);
            ack_model = 1'b0;
            if (!dmem_req) begin
                wcnt  = 0;
                acked = 1'b0;
            end else if (mem_en && !acked) begin
                if (wcnt == ack_delay) begin
                    ack_model = 1'b1;
                    rd_model  = rd_val;
                    acked     = 1'b1;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin : monitor
        logic req_prev;
        req_t req_cur;
        req_t req_now;
        req_prev = 1'b0;
        req_cur  = '0;
        forever begin
            @(negedge clk);
            req_now = '{we: dmem_we, addr: dmem_addr, wdata: dmem_wdata};
            if (dmem_req && !req_prev) begin
                if (req_exp.size() == 0) unexpected("req_unexpected", req_now);
                else begin
                    req_cur = req_exp.pop_front();
                    chk("req_we", dmem_we, req_cur.we);
                    chk("req_addr", dmem_addr, req_cur.addr);
                    chk("req_wdata", dmem_wdata, req_cur.wdata);
                end
            end else if (dmem_req) begin
                chk("req_stable", req_now, req_cur);
            end
            if (load_valid) begin
                if (ld_exp.size() == 0) unexpected("load_unexpected", load_data);
                else chk("load_data", load_data, ld_exp.pop_front());
            end
            if (pc_redirect) begin
                if (br_exp.size() == 0) unexpected("redirect_unexpected", pc_redirect_target);
                else chk("redirect_target", pc_redirect_target, br_exp.pop_front());
            end
            if (flush_mem !== pc_redirect || flush_front !== pc_redirect)
                unexpected("flush_mismatch", {flush_mem, flush_front, pc_redirect});
            req_prev = dmem_req;
        end
    end

    task automatic clear_inputs();
        mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_alu_result = '0; mem_rs2_data = '0;
        mem_branch = 1'b0; mem_branch_ne = 1'b0; mem_zero = 1'b0; mem_branch_target = '0;
    endtask

    // Called just after a rising edge; returns just after the edge that ends DONE.
    task automatic do_mem(input logic rd, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int delay, input logic [DW-1:0] rdata,
                          input int exp_stall, input logic [DW-1:0] exp_ld, input string name);
        int n;
        mem_mem_read = rd; mem_mem_write = wr; mem_alu_result = addr; mem_rs2_data = wdata;
        ack_delay = delay; rd_val = rdata;
        req_exp.push_back('{we: wr, addr: addr, wdata: wdata});
        if (rd) ld_exp.push_back(exp_ld);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!stall_mem) break;
            n++;
        end
        chk({name, "_stall_cycles"}, n, exp_stall);
        chk({name, "_done_busy"}, busy, 1'b1);
        chk({name, "_done_req"}, dmem_req, 1'b0);
        chk({name, "_done_load_valid"}, load_valid, rd);
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic do_branch(input logic b, input logic bne, input logic z,
                             input logic [15:0] tgt, input logic exp_taken, input string name);
        mem_branch = b; mem_branch_ne = bne; mem_zero = z; mem_branch_target = tgt;
        if (exp_taken) br_exp.push_back(tgt);
        @(negedge clk);
        chk({name, "_redirect"}, pc_redirect, exp_taken);
        chk({name, "_stall"}, stall_mem, 1'b0);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk({name, "_one_cycle"}, pc_redirect, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_we", dmem_we, 1'b0);
        chk("rst_addr", dmem_addr, 16'h0);
        chk("rst_wdata", dmem_wdata, 16'h0);
        chk("rst_load_data", load_data, 16'h0);
        chk("rst_load_valid", load_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Load, ack on second ACCESS cycle; zero-wait store
        do_mem(1'b1, 1'b0, 16'h0040, 16'h0000, 1, 16'hBEEF, 3, 16'hBEEF, "load_beef");
        do_mem(1'b0, 1'b1, 16'h0010, 16'h1234, 0, 16'h0000, 2, 16'h0000, "store_1234");
        chk("store_keeps_load_data", load_data, 16'hBEEF);

        do_branch(1'b1, 1'b0, 1'b1, 16'h0080, 1'b1, "beq_z1");
        do_branch(1'b0, 1'b1, 1'b1, 16'h00C0, 1'b0, "bne_z1");
        do_branch(1'b0, 1'b1, 1'b0, 16'h0100, 1'b1, "bne_z0");
        do_branch(1'b1, 1'b0, 1'b0, 16'h0140, 1'b0, "beq_z0");

        // Access with branch bits set: branch must be ignored
        mem_branch = 1'b1; mem_zero = 1'b1; mem_branch_target = 16'h0F00;
        do_mem(1'b1, 1'b0, 16'h0020, 16'h0000, 2, 16'h0A0A, 4, 16'h0A0A, "load_with_beq");

        // Back-to-back loads
        do_mem(1'b1, 1'b0, 16'h0100, 16'h0000, 0, 16'h1111, 2, 16'h1111, "b2b_first");
        do_mem(1'b1, 1'b0, 16'h0102, 16'h0000, 0, 16'h2222, 2, 16'h2222, "b2b_second");
        repeat (2) @(posedge clk);
        #1;

        // Reset while ACCESS, then a stray ack
        mem_en = 1'b0;
        mem_mem_read = 1'b1; mem_alu_result = 16'h0200;
        req_exp.push_back('{we: 1'b0, addr: 16'h0200, wdata: 16'h0000});
        @(negedge clk);
        @(negedge clk);
        chk("rstacc_req_before", dmem_req, 1'b1);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        chk("rstacc_req", dmem_req, 1'b0);
        chk("rstacc_busy", busy, 1'b0);
        chk("rstacc_stall", stall_mem, 1'b0);
        chk("rstacc_load_data", load_data, 16'h0);
        rst = 1'b1;
        force_ack = 1'b1; rd_force = 16'hDEAD;
        @(negedge clk);
        force_ack = 1'b0;
        chk("late_ack_load_valid", load_valid, 1'b0);
        chk("late_ack_busy", busy, 1'b0);
        @(negedge clk);
        chk("late_ack_load_valid2", load_valid, 1'b0);
        mem_en = 1'b1;
        @(posedge clk); #1;

        do_mem(1'b0, 1'b1, 16'hFFFE, 16'hFFFF, 3, 16'h0000, 5, 16'h0000, "store_top");
        do_mem(1'b1, 1'b0, 16'h0300, 16'h0000, 0, 16'hA5A5, 2, 16'hA5A5, "load_a5a5");

`ifdef MEM_TIMEOUT_EN
        mem_en = 1'b0;
        do_mem(1'b1, 1'b0, 16'h0310, 16'h0000, 0, 16'h0000, 1 + TMO, 16'h0000, "tmo_load");
        chk("tmo_err_set", timeout_err, 1'b1);
        chk("tmo_load_data", load_data, 16'h0);
        mem_en = 1'b1;
        do_mem(1'b1, 1'b0, 16'h0312, 16'h0000, 0, 16'h5555, 2, 16'h5555, "after_tmo");
        chk("tmo_err_sticky", timeout_err, 1'b1);
`else
        mem_en = 1'b0;
        repeat (3 * TMO) @(negedge clk);
        mem_en = 1'b1;
        chk("no_tmo_err", timeout_err, 1'b0);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("req_queue_drained", req_exp.size(), 0);
        chk("load_queue_drained", ld_exp.size(), 0);
        chk("redirect_queue_drained", br_exp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM stage of the Ak-16b pipeline. Sits between the EX2/MEM pipeline register and a multi-cycle data memory with a req/ack handshake. Stalls the MEM stage while a load/store is outstanding, returns load data to writeback, and resolves BEQ/BNE in MEM, generating the flush and PC-redirect pulses.

## Interface
Parameters:
- `ADDR_W`, 16, data-memory address width
- `DATA_W`, 16, data width
- `TIMEOUT_CYCLES`, 15, max ACCESS cycles before abort (used only with `MEM_TIMEOUT_EN`); legal range 1..255

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-low reset (0 = reset)
- `mem_mem_read`  in  1  MEM-stage instruction is a load
- `mem_mem_write`  in  1  MEM-stage instruction is a store
- `mem_alu_result`  in  ADDR_W  effective address
- `mem_rs2_data`  in  DATA_W  store data
- `mem_branch`, `mem_branch_ne`, `mem_zero`  in  1 each  branch controls
- `mem_branch_target`  in  16  branch target PC
- `dmem_req`  out  1  memory request, registered
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  ADDR_W  request address, registered
- `dmem_wdata`  out  DATA_W  request write data, registered
- `dmem_ack`  in  1  access complete, one-cycle pulse
- `dmem_rdata`  in  DATA_W  read data, valid with `dmem_ack`
- `stall_mem`  out  1  hold EX2/MEM register and everything upstream
- `flush_mem`  out  1  clear EX2/MEM register input
- `flush_front`  out  1  flush IF through EX2
- `pc_redirect`  out  1  load PC from `pc_redirect_target`
- `pc_redirect_target`  out  16  redirect PC
- `load_data`  out  DATA_W  captured load result
- `load_valid`  out  1  one-cycle pulse, `load_data` valid
- `busy`  out  1  FSM not in IDLE
- `timeout_err`  out  1  sticky abort flag

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - `access = mem_mem_read | mem_mem_write`.
  - If `access`: `stall_mem=1` (combinational). Register `dmem_addr`, `dmem_wdata`, and `dmem_we = mem_mem_write`. Set `dmem_req=1`. Go to ACCESS.
- ACCESS:
  - `stall_mem=1`. `dmem_req` held at 1 with address, data, and we stable.
  - On `dmem_ack`: `dmem_req` goes to 0 next cycle. For a load, capture `dmem_rdata` into `load_data` and pulse `load_valid` in the following cycle. Go to DONE.
- DONE:
  - `stall_mem=0` for exactly one cycle so the instruction leaves MEM. Return to IDLE.
  - The same instruction is never re-issued.
- Branch:
  - `taken = (mem_branch & mem_zero) | (mem_branch_ne & ~mem_zero)`.
  - Evaluated only in IDLE with `access=0`.
  - When taken: `flush_mem`, `flush_front`, and `pc_redirect` are 1 combinationally, and `pc_redirect_target = mem_branch_target`. Otherwise all three are 0.
  - Pulse is one cycle by construction, because the flushed register no longer holds the branch.
- Simultaneous branch and access (illegal encoding): access wins, branch is ignored.
- `dmem_ack` in IDLE or DONE is ignored.
- `busy = (state != IDLE)`.

## Timing
- Reset (`rst=0` at a rising edge): state = IDLE. `dmem_req`, `dmem_we`, `load_valid`, and `timeout_err` = 0. `dmem_addr`, `dmem_wdata`, and `load_data` = 0. Timeout counter = 0.
- Reset mid-ACCESS drops `dmem_req` on that edge. A late ack after reset is ignored.
- Non-memory instruction: 1 cycle in MEM, no stall.
- Memory op with ack in the first ACCESS cycle: 3 cycles in MEM (IDLE-stall, ACCESS, DONE). Each extra wait cycle adds 1.
- `load_valid` is asserted in the DONE cycle.
- `dmem_req` rises one cycle after the access is detected and falls the cycle after ack.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter counts ACCESS cycles.
  - On reaching `TIMEOUT_CYCLES` without ack: drop `dmem_req`, set `timeout_err` (sticky until reset), go to DONE with `load_data = 0` and `load_valid = 1`.
- `MEM_TIMEOUT_EN` undefined: ACCESS waits indefinitely, `timeout_err` is tied to 0, and no counter is built.

## Structure
- Shared package `ak16_pkg`: state enum (`MEM_IDLE`, `MEM_ACCESS`, `MEM_DONE`), `DATA_W` and `ADDR_W` defaults, branch-taken function.
- Optional sub-module `mem_timeout_ctr` (load, clear, expire output), instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- Load from 0x0040 with ack 2 cycles after req and rdata 0xBEEF:
  - `stall_mem` high for 3 cycles.
  - `load_data=0xBEEF` with `load_valid` pulsed once.
  - `dmem_req` falls the cycle after ack.
- Store of 0x1234 to 0x0010 with zero-wait ack:
  - `dmem_we=1`, addr and data stable while req is high.
  - 3-cycle MEM occupancy, no `load_valid`.
- BEQ with zero=1, target 0x0080: one-cycle `flush_mem`/`flush_front`/`pc_redirect` with target 0x0080. BNE with zero=1: no flush.
- `rst` driven low during ACCESS:
  - Next edge: IDLE, `dmem_req=0`, stall released.
  - Ack pulse 1 cycle later produces no `load_valid`.
- `MEM_TIMEOUT_EN` with `TIMEOUT_CYCLES=4` and no ack:
  - Req dropped after 4 ACCESS cycles.
  - `timeout_err=1` and stays 1; `load_data=0`.
- Back-to-back loads: the second load is detected in IDLE the cycle after DONE. No duplicate request for the first load.
